// File: rtl/inst_queue_pkg.sv
// Shared widths and control encodings for the instruction queue.
package inst_queue_pkg;

  localparam int IQ_XLEN   = 32;
  localparam int IQ_ADDR_W = 4;
  localparam int IQ_DEPTH  = 1 << IQ_ADDR_W;

  // Occupancy update selected each cycle.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_INC  = 2'd1,
    CNT_DEC  = 2'd2,
    CNT_CLR  = 2'd3
  } cnt_op_e;

endpackage

// File: rtl/inst_queue_if.sv
// Fetch-side push channel and decode-side ready/valid pop channel.
interface inst_queue_if #(
  parameter int XLEN = 32
);
  logic            IF_push;
  logic [XLEN-1:0] IF_inst;
  logic [XLEN-1:0] IF_pc;
  logic            IF_pred_taken;
  logic            IF_full;

  logic            ID_ready;
  logic            ID_valid;
  logic [XLEN-1:0] ID_inst;
  logic [XLEN-1:0] ID_pc;
  logic            ID_pred_taken;

  // Fetch/decode side driving the queue.
  modport master (
    output IF_push, IF_inst, IF_pc, IF_pred_taken, ID_ready,
    input  IF_full, ID_valid, ID_inst, ID_pc, ID_pred_taken
  );

  // The queue itself.
  modport slave (
    input  IF_push, IF_inst, IF_pc, IF_pred_taken, ID_ready,
    output IF_full, ID_valid, ID_inst, ID_pc, ID_pred_taken
  );
endinterface

// File: rtl/inst_queue_iq_ptr.sv
// Wrapping queue pointer with increment enable and synchronous clear.
module inst_queue_iq_ptr #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  output logic [ADDR_W-1:0] ptr
);

  // Clear wins over advance; the power-of-two depth makes wrap implicit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      ptr <= '0;
    else if (clr)  ptr <= '0;
    else if (en)   ptr <= ptr + 1'b1;
  end

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode: registered full
// back-pressure, first-word fall-through head, single-cycle flush.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int ADDR_W = IQ_ADDR_W,
  parameter int XLEN   = IQ_XLEN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              flush,
  inst_queue_if.slave       bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  logic [XLEN-1:0]   inst_mem [DEPTH];
  logic [XLEN-1:0]   pc_mem   [DEPTH];
  logic              pred_mem [DEPTH];

  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [ADDR_W:0]   count;
  logic              full;
  logic              empty;
  logic              flush_fire;
  logic              push_fire;
  logic              pop_fire;
  cnt_op_e           cnt_op;

  // Full/empty come from the count register only, so IF_full has no
  // combinational path from this cycle's push or pop.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);

  assign flush_fire = rdy & flush;
  assign push_fire  = rdy & bus.IF_push  & ~full  & ~flush;
  assign pop_fire   = rdy & bus.ID_ready & ~empty & ~flush;

  inst_queue_iq_ptr #(.ADDR_W(ADDR_W)) u_head (
    .clk (clk),
    .rst (rst),
    .en  (pop_fire),
    .clr (flush_fire),
    .ptr (head)
  );

  inst_queue_iq_ptr #(.ADDR_W(ADDR_W)) u_tail (
    .clk (clk),
    .rst (rst),
    .en  (push_fire),
    .clr (flush_fire),
    .ptr (tail)
  );

  // Pick the occupancy update; simultaneous push and pop cancel out.
  always_comb begin
    cnt_op = CNT_HOLD;
    if (flush_fire)                   cnt_op = CNT_CLR;
    else if (push_fire && !pop_fire)  cnt_op = CNT_INC;
    else if (pop_fire && !push_fire)  cnt_op = CNT_DEC;
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else begin
      case (cnt_op)
        CNT_CLR: count <= '0;
        CNT_INC: count <= count + 1'b1;
        CNT_DEC: count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_fire) begin
      inst_mem[tail] <= bus.IF_inst;
      pc_mem[tail]   <= bus.IF_pc;
      pred_mem[tail] <= bus.IF_pred_taken;
    end
  end

  assign bus.IF_full       = full;
  assign bus.ID_valid      = ~empty;
  assign bus.ID_inst       = empty ? '0   : inst_mem[head];
  assign bus.ID_pc         = empty ? '0   : pc_mem[head];
  assign bus.ID_pred_taken = empty ? 1'b0 : pred_mem[head];

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue with a queue-based model.
module tb_inst_queue;

  localparam int XLEN  = 32;
  localparam int DEPTH = 16;

  typedef logic [2*XLEN:0]   ent_t;   // {pred, pc, inst}
  typedef logic [2*XLEN+2:0] obs_t;   // {valid, full, pred, pc, inst}

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic flush = 1'b0;

  inst_queue_if #(.XLEN(XLEN)) bus ();

  inst_queue #(.ADDR_W(4), .XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  ent_t mq[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic obs_t exp_vec();
    if (mq.size() == 0) return '0;
    return {1'b1, (mq.size() == DEPTH), mq[0]};
  endfunction

  function automatic obs_t act_vec();
    return {bus.ID_valid, bus.IF_full, bus.ID_pred_taken, bus.ID_pc, bus.ID_inst};
  endfunction

  task automatic drive(input bit push, input logic [31:0] pc, input logic [31:0] inst,
                       input bit pred, input bit ready, input bit fl);
    bus.IF_push       = push;
    bus.IF_pc         = pc;
    bus.IF_inst       = inst;
    bus.IF_pred_taken = pred;
    bus.ID_ready      = ready;
    flush             = fl;
  endtask

  // One clock: decide from the model what the queue must do, then apply it.
  task automatic cycle();
    bit   do_flush, do_push, do_pop;
    ent_t e;
    do_flush = rdy && flush;
    do_push  = rdy && bus.IF_push && (mq.size() < DEPTH) && !flush;
    do_pop   = rdy && bus.ID_ready && (mq.size() != 0) && !flush;
    e = {bus.IF_pred_taken, bus.IF_pc, bus.IF_inst};
    @(posedge clk);
    if (do_flush) begin
      mq.delete();
    end else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    rdy = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    #3;
    checks++; if (bus.ID_valid !== 1'b0)          begin failures++; $display("FAIL reset_valid got=%b want=0", bus.ID_valid); end
    checks++; if (bus.IF_full !== 1'b0)           begin failures++; $display("FAIL reset_full got=%b want=0", bus.IF_full); end
    checks++; if (bus.ID_inst !== 32'h0)          begin failures++; $display("FAIL reset_inst got=%h want=0", bus.ID_inst); end
    checks++; if (bus.ID_pc !== 32'h0)            begin failures++; $display("FAIL reset_pc got=%h want=0", bus.ID_pc); end
    checks++; if (bus.ID_pred_taken !== 1'b0)     begin failures++; $display("FAIL reset_pred got=%b want=0", bus.ID_pred_taken); end
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_push3();
    logic [31:0] insts [3] = '{32'h00000013, 32'h00100093, 32'h00200113};
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'(i * 4), insts[i], 0, 0, 0);
      cycle();
      checks++;
      if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h0 || bus.ID_inst !== 32'h00000013)
        begin failures++; $display("FAIL push3_head[%0d] got v=%b pc=%h inst=%h want v=1 pc=0 inst=00000013", i, bus.ID_valid, bus.ID_pc, bus.ID_inst); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.ID_pc !== 32'(i * 4) || bus.ID_inst !== insts[i])
        begin failures++; $display("FAIL push3_drain[%0d] got pc=%h inst=%h want pc=%h inst=%h", i, bus.ID_pc, bus.ID_inst, i * 4, insts[i]); end
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cycle();
    end
    checks++; if (bus.ID_valid !== 1'b0) begin failures++; $display("FAIL push3_empty got=%b want=0", bus.ID_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.IF_full !== 1'b0) begin failures++; $display("FAIL fill_early_full[%0d] got=%b want=0", i, bus.IF_full); end
      drive(1, 32'(i * 4), $urandom, 1'($urandom), 0, 0);
      cycle();
    end
    checks++; if (bus.IF_full !== 1'b1) begin failures++; $display("FAIL fill_full got=%b want=1", bus.IF_full); end
    drive(1, 32'h40, 32'hDEADBEEF, 1, 0, 0);
    cycle();
    checks++;
    if (bus.IF_full !== 1'b1 || act_vec() !== exp_vec())
      begin failures++; $display("FAIL fill_17th got=%h want=%h", act_vec(), exp_vec()); end
    for (int i = 0; i < DEPTH; i++) begin
      checks++;
      if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'(i * 4) || act_vec() !== exp_vec())
        begin failures++; $display("FAIL fill_drain[%0d] got pc=%h v=%b want pc=%h v=1", i, bus.ID_pc, bus.ID_valid, i * 4); end
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cycle();
    end
    checks++; if (bus.ID_valid !== 1'b0) begin failures++; $display("FAIL fill_empty got=%b want=0", bus.ID_valid); end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 32'h200 + 32'(i * 4), $urandom, 0, 0, 0);
      cycle();
    end
    drive(1, 32'h300, 32'h12345678, 1, 1, 0);
    cycle();
    checks++;
    if (bus.IF_full !== 1'b0 || bus.ID_pc !== 32'h204)
      begin failures++; $display("FAIL fullpp_pop got full=%b pc=%h want full=0 pc=00000204", bus.IF_full, bus.ID_pc); end
    drive(1, 32'h300, 32'h12345678, 1, 0, 0);
    cycle();
    checks++; if (bus.IF_full !== 1'b1) begin failures++; $display("FAIL fullpp_retry got full=%b want=1", bus.IF_full); end
    for (int i = 0; i < DEPTH; i++) begin
      logic [31:0] want;
      want = (i < DEPTH - 1) ? 32'h204 + 32'(i * 4) : 32'h300;
      checks++;
      if (bus.ID_pc !== want) begin failures++; $display("FAIL fullpp_drain[%0d] got pc=%h want=%h", i, bus.ID_pc, want); end
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cycle();
    end
    checks++; if (bus.ID_pred_taken !== 1'b0 || bus.ID_valid !== 1'b0) begin failures++; $display("FAIL fullpp_empty got v=%b want=0", bus.ID_valid); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 2; i++) begin
      drive(1, 32'h1000 + 32'(i * 4), $urandom, 0, 0, 0);
      cycle();
    end
    for (int k = 0; k < 20; k++) begin
      checks++;
      if (bus.ID_pc !== 32'h1000 + 32'(k * 4) || act_vec() !== exp_vec())
        begin failures++; $display("FAIL wrap[%0d] got pc=%h want=%h", k, bus.ID_pc, 32'h1000 + k * 4); end
      drive(1, 32'h1008 + 32'(k * 4), $urandom, 1'($urandom), 1, 0);
      cycle();
    end
    for (int k = 20; k < 22; k++) begin
      checks++;
      if (bus.ID_pc !== 32'h1000 + 32'(k * 4))
        begin failures++; $display("FAIL wrap_tail[%0d] got pc=%h want=%h", k, bus.ID_pc, 32'h1000 + k * 4); end
      drive(0, 32'h0, 32'h0, 0, 1, 0);
      cycle();
    end
    checks++; if (bus.ID_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b want=0", bus.ID_valid); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) begin
      drive(1, 32'h80 + 32'(i * 4), $urandom, 1, 0, 0);
      cycle();
    end
    drive(1, 32'hDEAD0000, 32'hDEADDEAD, 1, 1, 1);
    cycle();
    checks++;
    if (bus.ID_valid !== 1'b0 || bus.IF_full !== 1'b0 || bus.ID_pc !== 32'h0)
      begin failures++; $display("FAIL flush_clear got v=%b pc=%h want v=0 pc=0", bus.ID_valid, bus.ID_pc); end
    drive(1, 32'h100, 32'hCAFE0013, 1, 0, 0);
    cycle();
    checks++;
    if (bus.ID_valid !== 1'b1 || bus.ID_pc !== 32'h100 || bus.ID_inst !== 32'hCAFE0013 || bus.ID_pred_taken !== 1'b1)
      begin failures++; $display("FAIL flush_repush got v=%b pc=%h inst=%h want v=1 pc=00000100 inst=cafe0013", bus.ID_valid, bus.ID_pc, bus.ID_inst); end
  endtask

  task automatic test_rdy_freeze();
    obs_t snap;
    for (int i = 0; i < 3; i++) begin
      drive(1, 32'h104 + 32'(i * 4), $urandom, 0, 0, 0);
      cycle();
    end
    snap = act_vec();
    rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'(i), $urandom, $urandom, 1, 1'(i >> 1), 1'(i + 1));
      cycle();
      checks++;
      if (act_vec() !== snap) begin failures++; $display("FAIL freeze[%0d] got=%h want=%h", i, act_vec(), snap); end
    end
    rdy = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
    cycle();
    checks++; if (bus.ID_pc !== 32'h100 || act_vec() !== exp_vec()) begin failures++; $display("FAIL freeze_resume got pc=%h want=00000100", bus.ID_pc); end
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (bus.ID_valid !== 1'b0 || bus.IF_full !== 1'b0 || bus.ID_pc !== 32'h0)
      begin failures++; $display("FAIL async_reset got v=%b pc=%h want v=0 pc=0", bus.ID_valid, bus.ID_pc); end
    mq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      bit rd;
      rd = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      rdy = ($urandom_range(0, 7) != 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom, 1'($urandom), rd,
            $urandom_range(0, 39) == 0);
      cycle();
      checks++;
      if (act_vec() !== exp_vec())
        begin failures++; $display("FAIL random[%0d] got=%h want=%h", i, act_vec(), exp_vec()); end
    end
    rdy = 1'b1;
    drive(0, 32'h0, 32'h0, 0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_push3();
    test_fill_drain();
    test_full_push_pop();
    test_wrap();
    test_flush();
    test_rdy_freeze();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
